// File: rtl/input_vc_buffer.sv
// -----------------------------------------------------------------------------
// input_vc_buffer
//   Per-input-port virtual-channel flit buffer. Flits arriving on one link are
//   stored in one circular FIFO per VC. The first flit of each packet (a change
//   of id or req relative to the last flit accepted on that VC) is tagged with
//   a head bit. The head entry of every VC is presented to route compute and
//   switch allocation. Each dequeued flit returns one credit upstream.
//
// Ports
//   clk, n_rst        clock, asynchronous active-low reset
//   in_flit/in_valid  incoming flit and its valid strobe
//   in_vc             target VC of in_flit
//   pop[v]            allocator grant: dequeue the head of VC v
//   out_flit[v]       head flit of VC v
//   out_valid[v]      VC v non-empty
//   out_head[v]       out_flit[v] is the first flit of a packet
//   credit_return[v]  one-cycle pulse per flit dequeued from VC v
//   occupancy[v]      flits stored in VC v
//   overflow          sticky: a flit arrived for a full VC
// -----------------------------------------------------------------------------
package noc_pkg;
  typedef logic [3:0] pkt_id_t;
  typedef logic [3:0] node_id_t;
  typedef struct packed {
    pkt_id_t    id;
    node_id_t   req;
    logic [7:0] data;
  } flit_t;
endpackage

module input_vc_buffer
  import noc_pkg::*;
#(
  parameter int NUM_VCS = 2,
  parameter int DEPTH   = 4,
  parameter int VC_W    = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  flit_t                            in_flit,
  input  logic                             in_valid,
  input  logic [VC_W-1:0]                  in_vc,
  input  logic [NUM_VCS-1:0]               pop,
  output flit_t [NUM_VCS-1:0]              out_flit,
  output logic  [NUM_VCS-1:0]              out_valid,
  output logic  [NUM_VCS-1:0]              out_head,
  output logic  [NUM_VCS-1:0]              credit_return,
  output logic  [NUM_VCS-1:0][CNT_W-1:0]   occupancy,
  output logic                             overflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flit_t            mem_q      [NUM_VCS][DEPTH];
  logic [DEPTH-1:0] hd_q       [NUM_VCS];
  logic [PTR_W-1:0] rptr_q     [NUM_VCS];
  logic [PTR_W-1:0] rptr_d     [NUM_VCS];
  logic [PTR_W-1:0] wptr_q     [NUM_VCS];
  logic [PTR_W-1:0] wptr_d     [NUM_VCS];
  logic [CNT_W-1:0] cnt_q      [NUM_VCS];
  logic [CNT_W-1:0] cnt_d      [NUM_VCS];
  pkt_id_t          last_id_q  [NUM_VCS];
  pkt_id_t          last_id_d  [NUM_VCS];
  node_id_t         last_req_q [NUM_VCS];
  node_id_t         last_req_d [NUM_VCS];
  logic [NUM_VCS-1:0] last_vld_q, last_vld_d;
  logic [NUM_VCS-1:0] credit_q, credit_d;
  logic               ovf_q, ovf_d;
  logic [NUM_VCS-1:0] do_push, do_pop, new_head;

  // Circular pointer advance; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ovf_d = ovf_q;
    for (int v = 0; v < NUM_VCS; v++) begin
      do_pop[v]  = pop[v] && (cnt_q[v] != '0);
      // A pop in the same cycle frees a slot, so a full VC still accepts.
      do_push[v] = in_valid && (in_vc == VC_W'(v)) &&
                   ((cnt_q[v] != CNT_W'(DEPTH)) || do_pop[v]);
      if (in_valid && (in_vc == VC_W'(v)) && !do_push[v])
        ovf_d = 1'b1;

      new_head[v] = !last_vld_q[v] || (in_flit.id != last_id_q[v]) ||
                    (in_flit.req != last_req_q[v]);

      rptr_d[v]     = do_pop[v]  ? ptr_inc(rptr_q[v]) : rptr_q[v];
      wptr_d[v]     = do_push[v] ? ptr_inc(wptr_q[v]) : wptr_q[v];
      last_vld_d[v] = last_vld_q[v] | do_push[v];
      last_id_d[v]  = do_push[v] ? in_flit.id  : last_id_q[v];
      last_req_d[v] = do_push[v] ? in_flit.req : last_req_q[v];
      credit_d[v]   = do_pop[v];

      case ({do_push[v], do_pop[v]})
        2'b10:   cnt_d[v] = cnt_q[v] + 1'b1;
        2'b01:   cnt_d[v] = cnt_q[v] - 1'b1;
        default: cnt_d[v] = cnt_q[v];
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_q      <= 1'b0;
      credit_q   <= '0;
      last_vld_q <= '0;
      for (int v = 0; v < NUM_VCS; v++) begin
        rptr_q[v]     <= '0;
        wptr_q[v]     <= '0;
        cnt_q[v]      <= '0;
        last_id_q[v]  <= '0;
        last_req_q[v] <= '0;
        hd_q[v]       <= '0;
        for (int e = 0; e < DEPTH; e++)
          mem_q[v][e] <= '0;
      end
    end else begin
      ovf_q      <= ovf_d;
      credit_q   <= credit_d;
      last_vld_q <= last_vld_d;
      for (int v = 0; v < NUM_VCS; v++) begin
        rptr_q[v]     <= rptr_d[v];
        wptr_q[v]     <= wptr_d[v];
        cnt_q[v]      <= cnt_d[v];
        last_id_q[v]  <= last_id_d[v];
        last_req_q[v] <= last_req_d[v];
        if (do_push[v]) begin
          mem_q[v][wptr_q[v]] <= in_flit;
          hd_q[v][wptr_q[v]]  <= new_head[v];
        end
      end
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      out_flit[v]  = mem_q[v][rptr_q[v]];
      out_head[v]  = hd_q[v][rptr_q[v]];
      out_valid[v] = (cnt_q[v] != '0);
      occupancy[v] = cnt_q[v];
    end
  end

  assign credit_return = credit_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
module tb_input_vc_buffer;
  import noc_pkg::*;

  localparam int NUM_VCS = 2;
  localparam int DEPTH   = 4;
  localparam int VC_W    = 1;
  localparam int CNT_W   = 3;

  logic                           clk;
  logic                           n_rst;
  flit_t                          in_flit;
  logic                           in_valid;
  logic [VC_W-1:0]                in_vc;
  logic [NUM_VCS-1:0]             pop;
  flit_t [NUM_VCS-1:0]            out_flit;
  logic  [NUM_VCS-1:0]            out_valid;
  logic  [NUM_VCS-1:0]            out_head;
  logic  [NUM_VCS-1:0]            credit_return;
  logic  [NUM_VCS-1:0][CNT_W-1:0] occupancy;
  logic                           overflow;

  input_vc_buffer #(.NUM_VCS(NUM_VCS), .DEPTH(DEPTH), .VC_W(VC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .in_flit(in_flit), .in_valid(in_valid), .in_vc(in_vc),
    .pop(pop), .out_flit(out_flit), .out_valid(out_valid), .out_head(out_head),
    .credit_return(credit_return), .occupancy(occupancy), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    flit_t f;
    logic  hd;
  } ent_t;

  typedef struct {
    logic       v;
    int         vc;
    logic [3:0] id;
    logic [3:0] req;
    logic [1:0] p;
    int         occ0;
    int         occ1;
    logic       ovf;
  } vec_t;

  ent_t       mq     [NUM_VCS][$];
  logic       m_lv   [NUM_VCS];
  logic [3:0] m_lid  [NUM_VCS];
  logic [3:0] m_lreq [NUM_VCS];
  logic       m_ovf;
  int         dctr;
  int         n_chk;
  int         n_pass;
  vec_t       tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_clear();
    for (int w = 0; w < NUM_VCS; w++) begin
      mq[w].delete();
      m_lv[w]   = 1'b0;
      m_lid[w]  = '0;
      m_lreq[w] = '0;
    end
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of stimulus, keep the scoreboard in step, check after the edge.
  task automatic step(input logic v, input int vc, input logic [3:0] id,
                      input logic [3:0] req, input logic [NUM_VCS-1:0] p);
    logic [NUM_VCS-1:0] ecred;
    ent_t  e;
    flit_t f;
    ecred = '0;
    f = '{id: id, req: req, data: dctr[7:0]};
    dctr++;
    in_valid = v;
    in_vc    = vc[VC_W-1:0];
    in_flit  = f;
    pop      = p;
    for (int w = 0; w < NUM_VCS; w++) begin
      if (p[w] && mq[w].size() > 0) begin
        e = mq[w].pop_front();
        chk($sformatf("pop_flit[%0d]", w), out_flit[w], e.f);
        chk($sformatf("pop_head[%0d]", w), out_head[w], e.hd);
        ecred[w] = 1'b1;
      end
    end
    if (v) begin
      if (mq[vc].size() < DEPTH) begin
        e.f  = f;
        e.hd = !m_lv[vc] || (id != m_lid[vc]) || (req != m_lreq[vc]);
        mq[vc].push_back(e);
        m_lv[vc]   = 1'b1;
        m_lid[vc]  = id;
        m_lreq[vc] = req;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pop      = '0;
    for (int w = 0; w < NUM_VCS; w++) begin
      chk($sformatf("occupancy[%0d]", w), occupancy[w], mq[w].size());
      chk($sformatf("out_valid[%0d]", w), out_valid[w], mq[w].size() != 0);
      chk($sformatf("credit[%0d]", w), credit_return[w], ecred[w]);
      if (mq[w].size() > 0) begin
        chk($sformatf("head_flit[%0d]", w), out_flit[w], mq[w][0].f);
        chk($sformatf("head_bit[%0d]", w), out_head[w], mq[w][0].hd);
      end
    end
    chk("overflow", overflow, m_ovf);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    dctr = 1;
    model_clear();
    n_rst = 1'b0;
    in_valid = 1'b0;
    in_vc = '0;
    in_flit = '0;
    pop = '0;

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_head", out_head, 0);
    chk("rst_credit", credit_return, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_flit", out_flit, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    //            v  vc id   req  pop    occ0 occ1 ovf
    tbl.push_back('{1, 0, 4'd3, 4'd1, 2'b00, 1, 0, 0});  // packet 3: head
    tbl.push_back('{1, 0, 4'd3, 4'd1, 2'b00, 2, 0, 0});
    tbl.push_back('{1, 0, 4'd3, 4'd1, 2'b00, 3, 0, 0});
    tbl.push_back('{1, 0, 4'd4, 4'd1, 2'b00, 4, 0, 0});  // packet 4: head
    tbl.push_back('{1, 0, 4'd5, 4'd2, 2'b01, 4, 0, 0});  // push+pop at full
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b01, 3, 0, 0});
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b01, 2, 0, 0});
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b01, 1, 0, 0});
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b01, 0, 0, 0});  // late flit comes out last
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b01, 0, 0, 0});  // pop on empty: ignored
    tbl.push_back('{1, 0, 4'd6, 4'd2, 2'b01, 1, 0, 0});  // push+pop on empty
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b01, 0, 0, 0});
    tbl.push_back('{1, 1, 4'd7, 4'd3, 2'b00, 0, 1, 0});
    tbl.push_back('{1, 1, 4'd7, 4'd3, 2'b00, 0, 2, 0});
    tbl.push_back('{1, 1, 4'd7, 4'd3, 2'b00, 0, 3, 0});
    tbl.push_back('{1, 1, 4'd7, 4'd3, 2'b00, 0, 4, 0});
    tbl.push_back('{1, 1, 4'd8, 4'd3, 2'b00, 0, 4, 1});  // fifth flit dropped
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b10, 0, 3, 1});
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b10, 0, 2, 1});
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b10, 0, 1, 1});
    tbl.push_back('{0, 0, 4'd0, 4'd0, 2'b10, 0, 0, 1});  // overflow remains sticky

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].vc, tbl[i].id, tbl[i].req, tbl[i].p);
      chk($sformatf("tbl%0d_occ0", i), occupancy[0], tbl[i].occ0);
      chk($sformatf("tbl%0d_occ1", i), occupancy[1], tbl[i].occ1);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
    end

    // Interleaved traffic on both VCs, 3*DEPTH flits each, wrapping the pointers.
    for (int i = 0; i < 6 * DEPTH; i++)
      step(1'b1, i % 2, 4'((i / 4) % 16), 4'd1, (i % 3 != 0) ? 2'b11 : 2'b00);
    repeat (2 * DEPTH) step(1'b0, 0, 4'd0, 4'd0, 2'b11);

    // Reset in the middle of a cycle while a credit pulse is live.
    step(1'b1, 0, 4'd9, 4'd2, 2'b00);
    step(1'b1, 0, 4'd9, 4'd2, 2'b00);
    step(1'b0, 0, 4'd0, 4'd0, 2'b01);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_head", out_head, 0);
    chk("mid_rst_credit", credit_return, 0);
    chk("mid_rst_occupancy", occupancy, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_out_flit", out_flit, 0);
    model_clear();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    // Same id/req as before reset: the cleared record must still mark a head.
    step(1'b1, 0, 4'd9, 4'd2, 2'b00);
    chk("post_rst_head", out_head[0], 1'b1);
    step(1'b0, 0, 4'd0, 4'd0, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
